// File: rtl/signal_debounce_timer_pkg.sv
// Shared types for the signal debounce timer: FSM state encoding and glitch counter width.
// Optional glitch counter is enabled by SIGNAL_DEBOUNCE_GLITCH_CNT_EN.
package signal_debounce_timer_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StPendHi   = 2'b01,
    StStableHi = 2'b11,
    StPendLo   = 2'b10
  } db_state_e;

  localparam int unsigned GlitchCntWidth = 8;

endpackage

// File: rtl/signal_debounce_timer_if.sv
// Tick/input and debounced-output bundle for signal_debounce_timer.
// glitch_cnt exists only when SIGNAL_DEBOUNCE_GLITCH_CNT_EN is defined.
interface signal_debounce_timer_if;
  import signal_debounce_timer_pkg::*;

  logic tick_1ms;
  logic sig_in;
  logic db_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  logic [GlitchCntWidth-1:0] glitch_cnt;

  modport master (
    output tick_1ms, sig_in,
    input  db_out, rise_pulse, fall_pulse, busy, glitch_cnt
  );
  modport slave (
    input  tick_1ms, sig_in,
    output db_out, rise_pulse, fall_pulse, busy, glitch_cnt
  );
`else
  modport master (
    output tick_1ms, sig_in,
    input  db_out, rise_pulse, fall_pulse, busy
  );
  modport slave (
    input  tick_1ms, sig_in,
    output db_out, rise_pulse, fall_pulse, busy
  );
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset to a configurable value.
module sync_2ff #(
  parameter bit ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/signal_debounce_timer.sv
// Debounces one async input against the 1 ms tick with separate rise/fall qualification.
// Define SIGNAL_DEBOUNCE_GLITCH_CNT_EN to add the saturating rejected-glitch counter.
module signal_debounce_timer
  import signal_debounce_timer_pkg::*;
#(
  parameter int unsigned         CntWidth  = 8,
  parameter logic [CntWidth-1:0] RiseMs    = 8'd10,
  parameter logic [CntWidth-1:0] FallMs    = 8'd2,
  parameter bit                  InitValue = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  signal_debounce_timer_if.slave bus
);

  logic                sig_s;
  db_state_e           state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                db_q, db_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  logic                      glitch_abort;
  logic [GlitchCntWidth-1:0] glitch_q;
`endif

  sync_2ff #(
    .ResetValue (InitValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.sig_in),
    .q_o    (sig_s)
  );

  assign cnt_inc = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};

  // A revert of sig_s takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    glitch_abort = 1'b0;
`endif
    unique case (state_q)
      StStableLo: begin
        if (sig_s) begin
          state_d = StPendHi;
          cnt_d   = '0;
        end
      end
      StPendHi: begin
        if (!sig_s) begin
          state_d = StStableLo;
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
          glitch_abort = 1'b1;
`endif
        end else if (bus.tick_1ms) begin
          if (cnt_inc == RiseMs) begin
            state_d = StStableHi;
            cnt_d   = '0;
            db_d    = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StStableHi: begin
        if (!sig_s) begin
          state_d = StPendLo;
          cnt_d   = '0;
        end
      end
      StPendLo: begin
        if (sig_s) begin
          state_d = StStableHi;
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
          glitch_abort = 1'b1;
`endif
        end else if (bus.tick_1ms) begin
          if (cnt_inc == FallMs) begin
            state_d = StStableLo;
            cnt_d   = '0;
            db_d    = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StStableLo;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= InitValue ? StStableHi : StStableLo;
      cnt_q   <= '0;
      db_q    <= InitValue;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      glitch_q <= '0;
    end else if (glitch_abort && (glitch_q != {GlitchCntWidth{1'b1}})) begin
      glitch_q <= glitch_q + GlitchCntWidth'(1);
    end
  end

  assign bus.glitch_cnt = glitch_q;
`endif

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = (state_q == StPendHi) || (state_q == StPendLo);

endmodule

// File: tb/tb_signal_debounce_timer.sv
// Directed self-checking bench for signal_debounce_timer (RiseMs=10, FallMs=2, InitValue=0).
// Define SIGNAL_DEBOUNCE_GLITCH_CNT_EN to also check the glitch counter.
module tb_signal_debounce_timer;

  localparam int TickGap = 19;  // idle cycles between ticks

  logic clk = 1'b0;
  logic rst_ni;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   rise_seen = 0;
  int   fall_seen = 0;
  int   rise_base;
  int   fall_base;

  signal_debounce_timer_if bus ();

  signal_debounce_timer #(
    .CntWidth  (8),
    .RiseMs    (8'd10),
    .FallMs    (8'd2),
    .InitValue (1'b0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rise_pulse) rise_seen++;
    if (bus.fall_pulse) fall_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_ms(input int n);
    repeat (n) begin
      bus.tick_1ms = 1'b1;
      step(1);
      bus.tick_1ms = 1'b0;
      step(TickGap);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    bus.sig_in   = 1'b1;
    bus.tick_1ms = 1'b0;
    step(3);
    check("rst_db", bus.db_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rise", bus.rise_pulse, 1'b0);
    check("rst_fall", bus.fall_pulse, 1'b0);
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    check("rst_gcnt", bus.glitch_cnt, 8'h00);
`endif

    // Release with sig_in high: 2 sync edges, then the FSM edge.
    rst_ni = 1'b1;
    step(2);
    check("rel_busy_early", bus.busy, 1'b0);
    step(1);
    check("rel_busy", bus.busy, 1'b1);

    // Clean rise: 9 ticks keep pending, 10th qualifies.
    rise_base = rise_seen;
    tick_ms(9);
    check("rise9_db", bus.db_out, 1'b0);
    check("rise9_busy", bus.busy, 1'b1);
    bus.tick_1ms = 1'b1;
    step(1);
    bus.tick_1ms = 1'b0;
    check("rise10_db", bus.db_out, 1'b1);
    check("rise10_pulse", bus.rise_pulse, 1'b1);
    check("rise10_busy", bus.busy, 1'b0);
    step(1);
    check("rise_pulse_end", bus.rise_pulse, 1'b0);
    step(5);
    check("rise_pulse_cnt", rise_seen - rise_base, 1);

    // Fall path with FallMs=2.
    fall_base = fall_seen;
    bus.sig_in = 1'b0;
    step(2);
    check("fall_busy_early", bus.busy, 1'b0);
    step(1);
    check("fall_busy", bus.busy, 1'b1);
    tick_ms(1);
    check("fall1_db", bus.db_out, 1'b1);
    bus.tick_1ms = 1'b1;
    step(1);
    bus.tick_1ms = 1'b0;
    check("fall2_db", bus.db_out, 1'b0);
    check("fall2_pulse", bus.fall_pulse, 1'b1);
    check("fall2_busy", bus.busy, 1'b0);
    step(1);
    check("fall_pulse_end", bus.fall_pulse, 1'b0);
    check("fall_pulse_cnt", fall_seen - fall_base, 1);

    // Glitch: high for 3 ticks, then low.
    rise_base = rise_seen;
    bus.sig_in = 1'b1;
    step(3);
    check("glitch_busy", bus.busy, 1'b1);
    tick_ms(3);
    bus.sig_in = 1'b0;
    step(2);
    check("glitch_busy_hold", bus.busy, 1'b1);
    step(1);
    check("glitch_busy_drop", bus.busy, 1'b0);
    check("glitch_db", bus.db_out, 1'b0);
    check("glitch_no_rise", rise_seen - rise_base, 0);
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    check("glitch_gcnt", bus.glitch_cnt, 8'h01);
`endif

    // Revert coincides with the 10th tick: revert wins.
    bus.sig_in = 1'b1;
    step(3);
    tick_ms(9);
    bus.sig_in = 1'b0;
    step(2);
    bus.tick_1ms = 1'b1;
    step(1);
    bus.tick_1ms = 1'b0;
    check("simul_db", bus.db_out, 1'b0);
    check("simul_busy", bus.busy, 1'b0);
    check("simul_no_rise", rise_seen - rise_base, 0);
    step(3);
    check("simul_db_late", bus.db_out, 1'b0);
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    check("simul_gcnt", bus.glitch_cnt, 8'h02);
`endif

    // Tick held high: counter advances every cycle, rise on edge 13.
    bus.tick_1ms = 1'b1;
    bus.sig_in   = 1'b1;
    step(12);
    check("cont_db_pre", bus.db_out, 1'b0);
    check("cont_busy_pre", bus.busy, 1'b1);
    step(1);
    check("cont_db", bus.db_out, 1'b1);
    check("cont_pulse", bus.rise_pulse, 1'b1);
    bus.tick_1ms = 1'b0;
    step(1);
    check("cont_pulse_end", bus.rise_pulse, 1'b0);

    // Reset mid fall-pending after one tick.
    fall_base  = fall_seen;
    bus.sig_in = 1'b0;
    step(3);
    tick_ms(1);
    check("midrst_busy_pre", bus.busy, 1'b1);
    rst_ni = 1'b0;
    step(1);
    check("midrst_db", bus.db_out, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_fall", bus.fall_pulse, 1'b0);
    rst_ni = 1'b1;
    tick_ms(3);
    check("midrst_busy_after", bus.busy, 1'b0);
    check("midrst_no_fall", fall_seen - fall_base, 0);
`ifdef SIGNAL_DEBOUNCE_GLITCH_CNT_EN
    check("midrst_gcnt", bus.glitch_cnt, 8'h00);

    // 300 aborted glitches saturate the counter.
    rise_base = rise_seen;
    for (int i = 0; i < 300; i++) begin
      bus.sig_in = 1'b1;
      step(3);
      bus.sig_in = 1'b0;
      step(3);
    end
    step(3);
    check("sat_gcnt", bus.glitch_cnt, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      bus.sig_in = 1'b1;
      step(3);
      bus.sig_in = 1'b0;
      step(3);
    end
    step(3);
    check("sat_gcnt_hold", bus.glitch_cnt, 8'hFF);
    check("sat_no_rise", rise_seen - rise_base, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
